// File: rtl/program_loader.sv
// UART boot loader: receives an A5/length/data/checksum frame on uart_rx and
// writes the decoded 32-bit words into instruction memory, holding the core in reset.
module program_loader #(
  parameter int CLK_DIV    = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  done,
  output logic                  err
);

  // state | meaning
  // IDLE  | waiting for header byte 0xA5
  // LEN   | next byte is the word count (0 = 256)
  // DATA  | assembling little-endian words and writing them
  // CSUM  | next byte must equal the XOR of all data bytes
  // DONE  | load good, core released
  // ERR   | checksum or framing failure, core held in reset

  localparam int              CW     = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   FULL   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   HALF   = CW'(CLK_DIV / 2 - 1);
  localparam logic [7:0]      HEADER = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

  rx_state_t       rx_state, rx_next;
  logic            rx_s1, rx_s2, rx_d;
  logic [CW-1:0]   rx_cnt;
  logic            rx_tick;
  logic [2:0]      bit_idx;
  logic [7:0]      rx_shift;
  logic            byte_valid;
  logic            frame_err;

  state_t          state, state_next;
  logic [8:0]      words_left;
  logic [1:0]      byte_idx;
  logic [23:0]     word_lo;
  logic [7:0]      acc;

  assign rx_tick = (rx_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_d && !rx_s2) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_BITS;
      RX_BITS:  if (rx_tick && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // The counter preloads the half-bit delay while idle so the start-bit
  // check lands mid-bit, then every later sample is one full bit apart.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_cnt     <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: rx_cnt <= HALF;
        RX_START: begin
          if (rx_tick) begin
            rx_cnt  <= FULL;
            bit_idx <= '0;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_BITS: begin
          if (rx_tick) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
            rx_cnt   <= FULL;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            byte_valid <= rx_s2;
            frame_err  <= !rx_s2;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: rx_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (byte_valid && rx_shift == HEADER) state_next = LEN;
      LEN: begin
        if (frame_err)       state_next = ERR;
        else if (byte_valid) state_next = DATA;
      end
      // Leave DATA only once the final write strobe is on the bus.
      DATA: begin
        if (frame_err)                         state_next = ERR;
        else if (imem_we && words_left == 9'd1) state_next = CSUM;
      end
      CSUM: begin
        if (frame_err)       state_next = ERR;
        else if (byte_valid) state_next = (rx_shift == acc) ? DONE : ERR;
      end
      DONE, ERR: if (byte_valid && rx_shift == HEADER) state_next = LEN;
      default: state_next = IDLE;
    endcase
  end

  assign core_rst = (state != DONE);
  assign done     = (state == DONE);
  assign err      = (state == ERR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      word_lo    <= '0;
      acc        <= '0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we) begin
        imem_addr  <= imem_addr + 1'b1;
        words_left <= words_left - 1'b1;
      end
      if (byte_valid) begin
        case (state)
          LEN: begin
            words_left <= (rx_shift == 8'd0) ? 9'd256 : {1'b0, rx_shift};
            acc        <= '0;
            imem_addr  <= '0;
            byte_idx   <= '0;
          end
          DATA: begin
            acc      <= acc ^ rx_shift;
            byte_idx <= byte_idx + 1'b1;
            case (byte_idx)
              2'd0: word_lo[7:0]   <= rx_shift;
              2'd1: word_lo[15:8]  <= rx_shift;
              2'd2: word_lo[23:16] <= rx_shift;
              default: begin
                imem_we    <= 1'b1;
                imem_wdata <= {rx_shift, word_lo};
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frame vectors from a table plus
// hand-written glitch and mid-frame reset sequences.
module tb_program_loader;

  localparam int CLK_DIV    = 8;
  localparam int ADDR_WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  uart_rx;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  core_rst;
  logic                  done;
  logic                  err;

  program_loader #(.CLK_DIV(CLK_DIV), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  int                    wr_n  = 0;
  int                    bv_n  = 0;
  int                    dbl_n = 0;
  logic                  we_prev = 1'b0;
  logic [ADDR_WIDTH-1:0] wr_addr [64];
  logic [31:0]           wr_data [64];

  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] <= imem_addr;
        wr_data[wr_n] <= imem_wdata;
      end
      wr_n <= wr_n + 1;
    end
    if (imem_we && we_prev) dbl_n <= dbl_n + 1;
    we_prev <= imem_we;
    if (dut.byte_valid) bv_n <= bv_n + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    uart_rx = v;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    {31'd0, imem_we}, 32'd0);
    check({tag, "_addr"},  {24'd0, imem_addr}, 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_crst"},  {31'd0, core_rst}, 32'd1);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_err"},   {31'd0, err}, 32'd0);
  endtask

  // b holds the bytes MSB-first, left-justified; bad is the index of the
  // byte sent with a 0 stop bit (15 = none).
  typedef struct packed {
    logic [95:0] b;
    logic [3:0]  n;
    logic [3:0]  bad;
    logic [1:0]  nwr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        done;
  } vec_t;

  vec_t vec [6];

  initial begin
    int base;
    int bv_base;
    logic [7:0] byt;

    vec[0] = '{b: 96'hA5_01_13_00_00_00_13_00_00_00_00_00, n: 7,  bad: 15, nwr: 1,
               w0: 32'h00000013, w1: 32'h0, done: 1'b1};
    vec[1] = '{b: 96'hA5_02_93_00_50_00_13_01_A0_00_71_00, n: 11, bad: 15, nwr: 2,
               w0: 32'h00500093, w1: 32'h00A00113, done: 1'b1};
    vec[2] = '{b: 96'hA5_01_13_00_00_00_FF_00_00_00_00_00, n: 7,  bad: 15, nwr: 1,
               w0: 32'h00000013, w1: 32'h0, done: 1'b0};
    vec[3] = '{b: 96'hA5_01_13_00_00_00_00_00_00_00_00_00, n: 4,  bad: 3,  nwr: 0,
               w0: 32'h0, w1: 32'h0, done: 1'b0};
    vec[4] = '{b: 96'h00_FF_A5_01_13_00_00_00_13_00_00_00, n: 9,  bad: 15, nwr: 1,
               w0: 32'h00000013, w1: 32'h0, done: 1'b1};
    vec[5] = '{b: 96'hA5_01_78_56_34_12_08_00_00_00_00_00, n: 7,  bad: 15, nwr: 1,
               w0: 32'h12345678, w1: 32'h0, done: 1'b1};

    rst     = 1'b0;
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);

    // 2-cycle low glitch must not produce a byte; stray bytes before the header are ignored
    bv_base = bv_n;
    base    = wr_n;
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (12 * CLK_DIV) @(negedge clk);
    check("glitch_bv", bv_n - bv_base, 32'd0);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (CLK_DIV) @(negedge clk);
    check("prehdr_bv", bv_n - bv_base, 32'd2);
    check("prehdr_crst", {31'd0, core_rst}, 32'd1);
    check("prehdr_done", {31'd0, done}, 32'd0);
    check("prehdr_err", {31'd0, err}, 32'd0);
    check("prehdr_wr", wr_n - base, 32'd0);

    for (int i = 0; i < 6; i++) begin
      base = wr_n;
      for (int k = 0; k < int'(vec[i].n); k++) begin
        byt = vec[i].b[95 - 8 * k -: 8];
        send_byte(byt, (k != int'(vec[i].bad)));
        if (byt == 8'hA5 && k < 3) begin
          check($sformatf("v%0d_hdr_done", i), {31'd0, done}, 32'd0);
          check($sformatf("v%0d_hdr_err", i), {31'd0, err}, 32'd0);
          check($sformatf("v%0d_hdr_crst", i), {31'd0, core_rst}, 32'd1);
        end
      end
      repeat (2 * CLK_DIV) @(negedge clk);
      check($sformatf("v%0d_nwr", i), wr_n - base, {30'd0, vec[i].nwr});
      if (vec[i].nwr >= 2'd1) begin
        check($sformatf("v%0d_a0", i), {24'd0, wr_addr[base]}, 32'd0);
        check($sformatf("v%0d_w0", i), wr_data[base], vec[i].w0);
      end
      if (vec[i].nwr >= 2'd2) begin
        check($sformatf("v%0d_a1", i), {24'd0, wr_addr[base + 1]}, 32'd1);
        check($sformatf("v%0d_w1", i), wr_data[base + 1], vec[i].w1);
      end
      check($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, vec[i].done});
      check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, !vec[i].done});
      check($sformatf("v%0d_crst", i), {31'd0, core_rst}, {31'd0, !vec[i].done});
    end

    // reset in the middle of the 3rd data byte, then a clean reload
    base = wr_n;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clk);
    check("midrst_nwr", wr_n - base, 32'd0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (2 * CLK_DIV) @(negedge clk);
    check("reload_nwr", wr_n - base, 32'd1);
    check("reload_a0", {24'd0, wr_addr[base]}, 32'd0);
    check("reload_w0", wr_data[base], 32'hDEADBEEF);
    check("reload_done", {31'd0, done}, 32'd1);
    check("reload_crst", {31'd0, core_rst}, 32'd0);

    check("we_single_cycle", dbl_n, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 16, meaning clk cycles per UART bit (minimum 4).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the instruction-memory word-address width.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the system clock with all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning reset, synchronous, active-low.
REQ-005 The block SHALL have port uart_rx, input, 1 bit, meaning the serial line, 8N1, idle high.
REQ-006 The block SHALL have port imem_we, output, 1 bit, meaning the instruction-memory write strobe.
REQ-007 The block SHALL have port imem_addr, output, ADDR_WIDTH bits, meaning the word address of the write.
REQ-008 The block SHALL have port imem_wdata, output, 32 bits, meaning the instruction word to be written.
REQ-009 The block SHALL have port core_rst, output, 1 bit, meaning the core reset, active-high, held while loading.
REQ-010 The block SHALL have port done, output, 1 bit, meaning the last load completed with a valid checksum.
REQ-011 The block SHALL have port err, output, 1 bit, meaning the last load failed on checksum or framing.

Function
REQ-012 The UART receiver SHALL sync uart_rx through two flops and detect a start bit on a high-to-low edge.
REQ-013 The UART receiver SHALL re-sample the start bit at CLK_DIV/2 and abort if it is high, because that is a glitch.
REQ-014 The UART receiver SHALL sample 8 data bits LSB-first at CLK_DIV intervals, then sample the stop bit.
REQ-015 The UART receiver SHALL pulse a 1-cycle byte-valid strobe when the stop bit is 1.
REQ-016 A stop bit of 0 SHALL raise a framing error, and the byte SHALL be discarded.
REQ-017 The frame format SHALL be: header 0xA5; length byte N (word count, 0 means 256); N x 4 data bytes, little-endian per word; checksum byte.
REQ-018 The checksum byte SHALL equal the XOR of all data bytes.
REQ-019 The loader FSM SHALL have states IDLE, LEN, DATA, CSUM, DONE and ERR.
REQ-020 In IDLE, a byte of 0xA5 SHALL move the FSM to LEN, and any other byte SHALL be ignored.
REQ-021 In LEN, the received byte SHALL latch the word count, clear the XOR accumulator, set the address to 0, and move the FSM to DATA.
REQ-022 In DATA, byte k of each word SHALL be shifted into bits [8k+7:8k].
REQ-023 On the 4th byte of a word, the block SHALL assert imem_we for exactly 1 cycle, in the cycle after the byte strobe, with imem_addr equal to the current word index and imem_wdata equal to the assembled word.
REQ-024 imem_addr SHALL increment after each write and wrap modulo 2^ADDR_WIDTH.
REQ-025 After the Nth word is written, the FSM SHALL move to CSUM.
REQ-026 In CSUM, a received byte equal to the accumulator SHALL move the FSM to DONE, and any other byte SHALL move it to ERR.
REQ-027 A framing error in LEN, DATA or CSUM SHALL move the FSM to ERR, and words already written SHALL remain written.
REQ-028 core_rst SHALL be 1 in IDLE, LEN, DATA, CSUM and ERR, and 0 only in DONE.
REQ-029 done SHALL be 1 only in DONE, and err SHALL be 1 only in ERR.
REQ-030 In DONE or ERR, a 0xA5 byte SHALL restart the load, going to LEN with core_rst=1, done=0 and err=0 in the next cycle.
REQ-031 In DONE or ERR, any other byte SHALL be ignored.
REQ-032 A byte strobe and the write of the previous word SHALL never coincide, since CLK_DIV is at least 4 and one byte takes 10 x CLK_DIV cycles.
REQ-033 imem_we SHALL never assert outside DATA.

Reset
REQ-034 With rst=0 at a clk edge, the FSM SHALL go to IDLE and the UART receiver SHALL go to idle.
REQ-035 With rst=0 at a clk edge, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0 and err=0.
REQ-036 With rst=0 at a clk edge, the accumulator and counters SHALL be cleared.
REQ-037 Reset asserted mid-frame SHALL abandon the frame, and the partial byte or word SHALL not be written.
REQ-038 After reset the next frame SHALL start from the header.

Verification
REQ-039 The bench SHALL cover: A5 01 13 00 00 00 13 -> one imem_we pulse, addr 0, wdata 0x00000013; then done=1, core_rst=0.
REQ-040 The bench SHALL cover: A5 02, words 0x00500093 and 0x00A00113, checksum correct -> writes at addr 0 and addr 1; then done=1.
REQ-041 The bench SHALL cover: A5 01 13 00 00 00 FF -> one write, then err=1, done=0, core_rst=1.
REQ-042 The bench SHALL cover: a stop bit forced to 0 on the 2nd data byte -> err=1 and no imem_we.
REQ-043 The bench SHALL cover: a 2-cycle low glitch on uart_rx in IDLE -> no byte strobe and the state stays IDLE; also bytes 0x00 then 0xFF before the header -> ignored.
REQ-044 The bench SHALL cover: rst=0 during the 3rd data byte -> all outputs at reset values; then a full valid frame loads correctly from addr 0.
